// File: rtl/prbs_ber_ctrl.sv
// prbs_ber_ctrl
//   Sequences a PRBS generator/checker link and measures the bit-error count
//   over a programmed window. A local checker register is loaded from the
//   received stream (SYNC), proven against ORDER consecutive predictions
//   (VERIFY), then free-runs while compared bits and errors are counted
//   (MEASURE). DONE pulses o_done for one cycle before returning to IDLE.
//
//   Optional build macro: PRBS_BER_ERRINJ_EN adds i_inject. A pulse on it
//   arms a single forced error on the next counted bit in MEASURE.
//
// Ports
//   clock        system clock
//   i_reset      asynchronous active-high reset
//   i_start      start a measurement (accepted only in IDLE)
//   i_abort      return to IDLE from any state (wins over i_start)
//   i_win_len    compared bits per window, latched on accepted start
//   i_tick       symbol-rate strobe for the generator
//   i_rx_bit     received bit, qualified by i_rx_valid
//   i_inject     (PRBS_BER_ERRINJ_EN only) arm one forced error
//   o_gen_enable generator enable (SYNC/VERIFY/MEASURE)
//   o_gen_valid  i_tick & o_gen_enable
//   o_busy       not IDLE
//   o_locked     in MEASURE
//   o_done       one-cycle pulse at window end
//   o_bit_count  compared bits in current/last window
//   o_err_count  errors in current/last window, saturating
module prbs_ber_ctrl #(
  parameter int ORDER = 9,
  parameter int WIN_W = 16,
  parameter int ERR_W = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_tick,
  input  logic             i_rx_bit,
  input  logic             i_rx_valid,
`ifdef PRBS_BER_ERRINJ_EN
  input  logic             i_inject,
`endif
  output logic             o_gen_enable,
  output logic             o_gen_valid,
  output logic             o_busy,
  output logic             o_locked,
  output logic             o_done,
  output logic [WIN_W-1:0] o_bit_count,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int CNT_W = $clog2(ORDER + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_VERIFY,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [ORDER-1:0] r_chk;
  logic [CNT_W-1:0] r_cnt;        // SYNC load count / VERIFY good-bit run
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_bit_count;
  logic [ERR_W-1:0] r_err_count;

  logic             w_pred;
  logic [ORDER-1:0] w_chk_load;
  logic [ORDER-1:0] w_chk_run;
  logic             w_err;
  logic [WIN_W-1:0] w_bit_inc;
  logic             w_err_sat;
  logic             w_cnt_last;
  logic             w_meas_count;  // a bit is actually counted this cycle

  assign w_pred       = r_chk[ORDER-5] ^ r_chk[0];
  assign w_chk_load   = {i_rx_bit, r_chk[ORDER-1:1]};
  assign w_chk_run    = {w_pred, r_chk[ORDER-1:1]};
  assign w_bit_inc    = r_bit_count + 1'b1;
  assign w_err_sat    = &r_err_count;
  assign w_cnt_last   = (r_cnt == CNT_W'(ORDER - 1));
  assign w_meas_count = (r_state == S_MEASURE) && i_rx_valid && (r_bit_count != r_win);

`ifdef PRBS_BER_ERRINJ_EN
  logic r_inj_arm;

  // Set has priority over consumption so a pulse coinciding with a counted
  // bit arms the following one.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_inj_arm <= 1'b0;
    end else if (i_abort) begin
      r_inj_arm <= 1'b0;
    end else if (i_inject) begin
      r_inj_arm <= 1'b1;
    end else if (w_meas_count) begin
      r_inj_arm <= 1'b0;
    end
  end

  assign w_err = i_rx_bit ^ w_pred ^ (r_inj_arm && w_meas_count);
`else
  assign w_err = i_rx_bit ^ w_pred;
`endif

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_chk       <= '0;
      r_cnt       <= '0;
      r_win       <= '0;
      r_bit_count <= '0;
      r_err_count <= '0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_SYNC;
            r_win       <= i_win_len;
            r_bit_count <= '0;
            r_err_count <= '0;
            r_cnt       <= '0;
          end
        end
        S_SYNC: begin
          if (i_rx_valid) begin
            r_chk <= w_chk_load;
            if (w_cnt_last) begin
              r_cnt <= '0;
              // An all-zero register would predict zeros forever; reload.
              if (w_chk_load != '0) begin
                r_state <= S_VERIFY;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_VERIFY: begin
          if (i_rx_valid) begin
            r_chk <= w_chk_run;
            if (w_err) begin
              r_state <= S_SYNC;
              r_cnt   <= '0;
            end else if (w_cnt_last) begin
              r_state <= S_MEASURE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (r_bit_count == r_win) begin
            // Only reachable directly for a zero-length window.
            r_state <= S_DONE;
          end else if (i_rx_valid) begin
            r_chk       <= w_chk_run;
            r_bit_count <= w_bit_inc;
            if (w_err && !w_err_sat) begin
              r_err_count <= r_err_count + 1'b1;
            end
            if (w_bit_inc == r_win) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gen_enable = (r_state == S_SYNC) || (r_state == S_VERIFY) || (r_state == S_MEASURE);
  assign o_gen_valid  = i_tick & o_gen_enable;
  assign o_busy       = (r_state != S_IDLE);
  assign o_locked     = (r_state == S_MEASURE);
  assign o_done       = (r_state == S_DONE);
  assign o_bit_count  = r_bit_count;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
module tb_prbs_ber_ctrl;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_win_len;
  logic        i_tick;
  logic        i_rx_bit;
  logic        i_rx_valid;
  logic        i_inject;
  logic        inv2;
  logic        rx2;

  logic        o_gen_enable, o_gen_valid, o_busy, o_locked, o_done;
  logic [15:0] o_bit_count, o_err_count;

  logic        d2_gen_enable, d2_gen_valid, d2_busy, d2_locked, d2_done;
  logic [15:0] d2_bit_count;
  logic [3:0]  d2_err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] g;  // reference PRBS9 generator, x^9 + x^5 + 1

  assign rx2 = i_rx_bit ^ inv2;

  always #5 clock = ~clock;

  prbs_ber_ctrl dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_win_len    (i_win_len),
    .i_tick       (i_tick),
    .i_rx_bit     (i_rx_bit),
    .i_rx_valid   (i_rx_valid),
`ifdef PRBS_BER_ERRINJ_EN
    .i_inject     (i_inject),
`endif
    .o_gen_enable (o_gen_enable),
    .o_gen_valid  (o_gen_valid),
    .o_busy       (o_busy),
    .o_locked     (o_locked),
    .o_done       (o_done),
    .o_bit_count  (o_bit_count),
    .o_err_count  (o_err_count)
  );

  prbs_ber_ctrl #(.ERR_W(4)) dut2 (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_win_len    (i_win_len),
    .i_tick       (i_tick),
    .i_rx_bit     (rx2),
    .i_rx_valid   (i_rx_valid),
`ifdef PRBS_BER_ERRINJ_EN
    .i_inject     (1'b0),
`endif
    .o_gen_enable (d2_gen_enable),
    .o_gen_valid  (d2_gen_valid),
    .o_busy       (d2_busy),
    .o_locked     (d2_locked),
    .o_done       (d2_done),
    .o_bit_count  (d2_bit_count),
    .o_err_count  (d2_err_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gen_next(output logic b);
    b = g[0];
    g = {g[4] ^ g[0], g[8:1]};
  endtask

  // Present one valid received bit (optionally flipped) for one clock.
  task automatic feed(input logic flip);
    logic b;
    gen_next(b);
    i_rx_bit   = b ^ flip;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
  endtask

  task automatic start(input logic [15:0] win);
    i_win_len = win;
    i_start   = 1'b1;
    step();
    i_start   = 1'b0;
  endtask

  initial begin
    int done_seen;
    g          = 9'h1FF;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_win_len  = '0;
    i_tick     = 1'b1;
    i_rx_bit   = 1'b0;
    i_rx_valid = 1'b0;
    i_inject   = 1'b0;
    inv2       = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_gen_en", 32'(o_gen_enable), 0);
    chk("rst_gen_valid", 32'(o_gen_valid), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_bits", 32'(o_bit_count), 0);
    chk("rst_errs", 32'(o_err_count), 0);
    i_reset = 1'b0;
    step();

    // 1: clean loopback, window 1000
    start(16'd1000);
    chk("t1_busy", 32'(o_busy), 1);
    chk("t1_gen_en", 32'(o_gen_enable), 1);
    chk("t1_gen_valid", 32'(o_gen_valid), 1);
    i_tick = 1'b0;
    #1;
    chk("t1_gen_valid_notick", 32'(o_gen_valid), 0);
    i_tick = 1'b1;
    for (int k = 0; k < 17; k++) feed(1'b0);
    chk("t1_locked17", 32'(o_locked), 0);
    feed(1'b0);
    chk("t1_locked18", 32'(o_locked), 1);
    done_seen = 0;
    for (int k = 1; k <= 1000; k++) begin
      feed(1'b0);
      if (o_done) done_seen++;
    end
    chk("t1_done_now", 32'(o_done), 1);
    step();
    chk("t1_done_once", 32'(done_seen), 1);
    chk("t1_idle", 32'(o_busy), 0);
    chk("t1_done_gone", 32'(o_done), 0);
    chk("t1_bits", 32'(o_bit_count), 1000);
    chk("t1_errs", 32'(o_err_count), 0);

    // 2: two flipped bits inside MEASURE; stray start mid-window ignored
    start(16'd1000);
    chk("t2_cleared", 32'(o_bit_count), 0);
    for (int k = 0; k < 18; k++) feed(1'b0);
    chk("t2_locked", 32'(o_locked), 1);
    for (int k = 1; k <= 1000; k++) begin
      if (k == 300) begin
        i_start   = 1'b1;
        i_win_len = 16'd5;
      end
      feed(k == 100 || k == 500);
      i_start = 1'b0;
      if (k == 300) chk("t2_start_ignored", 32'(o_bit_count), 300);
    end
    step();
    chk("t2_bits", 32'(o_bit_count), 1000);
    chk("t2_errs", 32'(o_err_count), 2);

    // 3: all-zero stream never locks; abort returns to IDLE
    start(16'd10);
    for (int k = 0; k < 40; k++) begin
      i_rx_bit   = 1'b0;
      i_rx_valid = 1'b1;
      step();
    end
    i_rx_valid = 1'b0;
    chk("t3_busy", 32'(o_busy), 1);
    chk("t3_locked", 32'(o_locked), 0);
    chk("t3_gen_en", 32'(o_gen_enable), 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("t3_abort_idle", 32'(o_busy), 0);
    chk("t3_abort_nodone", 32'(o_done), 0);

    // 4: error during VERIFY re-syncs; VERIFY bits are not counted
    start(16'd20);
    for (int k = 0; k < 12; k++) feed(1'b0);
    feed(1'b1);
    chk("t4_unlocked", 32'(o_locked), 0);
    chk("t4_still_busy", 32'(o_busy), 1);
    for (int k = 0; k < 17; k++) feed(1'b0);
    chk("t4_locked30", 32'(o_locked), 0);
    feed(1'b0);
    chk("t4_locked31", 32'(o_locked), 1);
    chk("t4_bits_at_lock", 32'(o_bit_count), 0);
    for (int k = 0; k < 20; k++) feed(1'b0);
    chk("t4_done", 32'(o_done), 1);
    chk("t4_bits", 32'(o_bit_count), 20);
    chk("t4_errs", 32'(o_err_count), 0);
    step();

    // 5: zero-length window, then start+abort in the same cycle
    start(16'd0);
    for (int k = 0; k < 18; k++) feed(1'b0);
    chk("t5_locked", 32'(o_locked), 1);
    feed(1'b0);
    chk("t5_done", 32'(o_done), 1);
    chk("t5_bits", 32'(o_bit_count), 0);
    chk("t5_errs", 32'(o_err_count), 0);
    step();
    i_win_len = 16'd8;
    i_start   = 1'b1;
    i_abort   = 1'b1;
    step();
    i_start   = 1'b0;
    i_abort   = 1'b0;
    chk("t5_abort_wins", 32'(o_busy), 0);

    // 6: ERR_W=4 instance sees an inverted stream after lock -> saturates
    start(16'd40);
    for (int k = 0; k < 18; k++) feed(1'b0);
    chk("t6_d2_locked", 32'(d2_locked), 1);
    inv2 = 1'b1;
    for (int k = 0; k < 10; k++) feed(1'b0);
    chk("t6_d2_errs10", 32'(d2_err_count), 10);
    for (int k = 0; k < 30; k++) feed(1'b0);
    inv2 = 1'b0;
    chk("t6_d2_done", 32'(d2_done), 1);
    chk("t6_d2_bits", 32'(d2_bit_count), 40);
    chk("t6_d2_errs_sat", 32'(d2_err_count), 15);
    chk("t6_clean_errs", 32'(o_err_count), 0);
    step();

    // 7: abort inside MEASURE holds counters, no done
    start(16'd100);
    for (int k = 0; k < 28; k++) feed(1'b0);
    chk("t7_bits10", 32'(o_bit_count), 10);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("t7_idle", 32'(o_busy), 0);
    chk("t7_nodone", 32'(o_done), 0);
    for (int k = 0; k < 5; k++) feed(1'b0);
    chk("t7_bits_hold", 32'(o_bit_count), 10);

    // 8: asynchronous reset mid-window, checked before the next edge
    start(16'd100);
    for (int k = 0; k < 25; k++) feed(1'b0);
    chk("t8_bits7", 32'(o_bit_count), 7);
    i_reset = 1'b1;
    #2;
    chk("t8_async_busy", 32'(o_busy), 0);
    chk("t8_async_bits", 32'(o_bit_count), 0);
    step();
    i_reset = 1'b0;
    step();

`ifdef PRBS_BER_ERRINJ_EN
    // 9: one injection pulse on a clean link forces exactly one error
    start(16'd50);
    for (int k = 0; k < 18; k++) feed(1'b0);
    i_inject = 1'b1;
    step();
    i_inject = 1'b0;
    for (int k = 0; k < 50; k++) feed(1'b0);
    chk("t9_inj_bits", 32'(o_bit_count), 50);
    chk("t9_inj_errs", 32'(o_err_count), 1);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
